// File: rtl/ncl_sync_rx.sv
// ---------------------------------------------------------------------------
// ncl_sync_rx
// Receiving end of a dual-rail NCL datapath. Synchronizes the true/false
// rails into the clock domain, decodes DATA/NULL completion, drives the
// completion acknowledge ko back to the NCL stage, and delivers each DATA
// word to a valid/ready stream through a DEPTH-entry FIFO.
//
// Optional feature macro: NCL_RX_ILLEGAL_DET_EN
//   defined   : a synchronized bit with both rails high sets the sticky err
//               flag, and the FSM holds its state while any bit is illegal.
//   undefined : no illegal-code logic; err tied to 0.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset (deasserted synchronously
//                   inside the block)
//   d_t        in   WIDTH true rails (asynchronous)
//   d_f        in   WIDTH false rails (asynchronous)
//   ko         out  1 = request DATA, 0 = request NULL (registered)
//   out_data   out  head-of-FIFO word
//   out_valid  out  out_data valid
//   out_ready  in   consumer accepts when out_valid & out_ready
//   out_level  out  FIFO occupancy
//   err        out  sticky illegal-code flag
// ---------------------------------------------------------------------------
module ncl_sync_rx #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         d_t,
    input  logic [WIDTH-1:0]         d_f,
    output logic                     ko,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   out_level,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {
        WAIT_NULL = 1'b0,
        REQ_DATA  = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Reset synchronizer. Its length matches the rail synchronizer so that,
    // when reset is released with DATA still on the rails, the FSM first
    // sees the real synchronized rails instead of the all-zero reset value
    // (which would look like NULL and raise ko prematurely).
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] rst_sync;
    logic                   rst_int_n;

    // NOTE: sequential state is always assigned with non-blocking (<=) so every
    // flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
    end

    assign rst_int_n = rst_sync[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Rail synchronizers. Cleared by the raw reset so they resume sampling
    // while the internal reset is still being held.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] sync_t [SYNC_STAGES];
    logic [WIDTH-1:0] sync_f [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_t[i] <= '0;
                sync_f[i] <= '0;
            end
        end else begin
            sync_t[0] <= d_t;
            sync_f[0] <= d_f;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_t[i] <= sync_t[i-1];
                sync_f[i] <= sync_f[i-1];
            end
        end
    end

    logic [WIDTH-1:0] s_t;
    logic [WIDTH-1:0] s_f;
    logic             all_data;
    logic             all_null;
    logic             illegal;

    assign s_t      = sync_t[SYNC_STAGES-1];
    assign s_f      = sync_f[SYNC_STAGES-1];
    // Exactly one rail high per bit; a both-high bit fails the XOR.
    assign all_data = &(s_t ^ s_f);
    assign all_null = ~|(s_t | s_f);

`ifdef NCL_RX_ILLEGAL_DET_EN
    logic err_q;

    assign illegal = |(s_t & s_f);

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n)   err_q <= 1'b0;
        else if (illegal) err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign illegal = 1'b0;
    assign err     = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FIFO bookkeeping. Pointers carry one extra MSB so full and empty are
    // distinguished by wrap-around; occupancy is their difference.
    // -----------------------------------------------------------------------
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [LW-1:0]    level;
    logic             full;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] mem [DEPTH];

    assign level     = wr_ptr - rd_ptr;
    assign full      = (level == LW'(DEPTH));
    assign out_valid = (level != '0);
    assign pop       = out_valid & out_ready;
    assign out_level = level;
    assign out_data  = mem[rd_ptr[AW-1:0]];

    // -----------------------------------------------------------------------
    // Handshake FSM. ko is the state itself, so it is a registered output.
    // A DATA request is only issued with a free slot, and pops can only add
    // room, so the push in REQ_DATA never overflows.
    // -----------------------------------------------------------------------
    state_t state;
    state_t state_nx;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) state <= WAIT_NULL;
        else            state <= state_nx;
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        push     = 1'b0;
        case (state)
            WAIT_NULL: begin
                if (all_null && !full && !illegal) state_nx = REQ_DATA;
            end
            REQ_DATA: begin
                if (all_data && !illegal) begin
                    push     = 1'b1;
                    state_nx = WAIT_NULL;
                end
            end
            default: state_nx = WAIT_NULL;
        endcase
    end

    assign ko = (state == REQ_DATA);

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array is reset on purpose: out_data reads the head
    // entry directly and must be 0 out of reset, and the array is only DEPTH
    // words deep.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr[AW-1:0]] <= s_t;
        end
    end

endmodule
